// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the core memory port and data memory.
// Latches a core access, drives the memory with a word address, byte enables
// and replicated write data, waits for mem_ready_i (bounded by TIMEOUT_CYCLES),
// then returns sign/zero-extended load data. Produces the core stall.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/W accesses trap (IDLE -> DONE, err_o, rd = 0)
//   undefined : low address bits are forced aligned and the access proceeds
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   core_req_i/we_i/size_i/addr_i/wd_i : core access request
//   core_rd_o    : formatted load data, valid in DONE
//   core_stall_o : core hold, combinational
//   mem_req_o/we_o/be_o/addr_o/wd_o   : registered memory request, zero outside REQ
//   mem_rd_i, mem_ready_i             : memory response
//   err_o        : one-cycle pulse on trap, timeout or illegal size
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  // Counter value seen in the last permitted REQ cycle.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wd_q, mem_wd_d;

  // Decode of the incoming core access.
  logic        is_byte, is_half, illegal, trap;
  logic [3:0]  be_new;
  logic [31:0] wd_new;
  logic [1:0]  off_new;

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    illegal = 1'b0;
    case (core_size_i)
      3'd0, 3'd4: is_byte = 1'b1;
      3'd1, 3'd5: is_half = 1'b1;
      3'd2:       ;
      default:    illegal = 1'b1;
    endcase
    if (is_byte) begin
      be_new  = 4'b0001 << core_addr_i[1:0];
      wd_new  = {4{core_wd_i[7:0]}};
      off_new = core_addr_i[1:0];
    end else if (is_half) begin
      be_new  = 4'b0011 << {core_addr_i[1], 1'b0};
      wd_new  = {2{core_wd_i[15:0]}};
      off_new = {core_addr_i[1], 1'b0};
    end else begin
      be_new  = 4'b1111;
      wd_new  = core_wd_i;
      off_new = 2'b00;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (is_half & core_addr_i[0]) | ((core_size_i == 3'd2) & (|core_addr_i[1:0]));
`else
    trap = 1'b0;
`endif
  end

  // Load data formatting from the latched size and byte offset.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rd_fmt;

  always_comb begin
    byte_sel = mem_rd_i[{off_q, 3'b000} +: 8];
    half_sel = mem_rd_i[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      3'd0:    rd_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    rd_fmt = {24'h0, byte_sel};
      3'd1:    rd_fmt = {{16{half_sel[15]}}, half_sel};
      3'd5:    rd_fmt = {16'h0, half_sel};
      default: rd_fmt = mem_rd_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    err_d      = 1'b0;
    // Memory outputs default to zero so they are only live in REQ.
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    mem_be_d   = 4'h0;
    mem_addr_d = 32'h0;
    mem_wd_d   = 32'h0;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (trap) begin
            state_d = DONE;
            rd_d    = 32'h0;
            err_d   = 1'b1;
          end else begin
            state_d    = REQ;
            size_d     = core_size_i;
            off_d      = off_new;
            cnt_d      = 16'h0;
            err_d      = illegal;
            mem_req_d  = 1'b1;
            mem_we_d   = core_we_i;
            mem_be_d   = be_new;
            mem_addr_d = {core_addr_i[31:2], 2'b00};
            mem_wd_d   = wd_new;
          end
        end
      end
      REQ: begin
        cnt_d = (cnt_q != 16'hFFFF) ? cnt_q + 16'h1 : cnt_q;
        if (mem_ready_i) begin
          // Ready has priority over a simultaneous timeout.
          if (!mem_we_q) rd_d = rd_fmt;
          state_d = DONE;
        end else if (cnt_q >= LIMIT) begin
          rd_d    = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          mem_req_d  = mem_req_q;
          mem_we_d   = mem_we_q;
          mem_be_d   = mem_be_q;
          mem_addr_d = mem_addr_q;
          mem_wd_d   = mem_wd_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      size_q     <= 3'd0;
      off_q      <= 2'd0;
      cnt_q      <= 16'h0;
      rd_q       <= 32'h0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'h0;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  assign core_rd_o    = rd_q;
  assign core_stall_o = core_req_i & (state_q != DONE);
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wd_o     = mem_wd_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl with TIMEOUT_CYCLES = 4: table of single-access vectors
// plus hand-written sequences for stall timing, timeout, ready-at-limit,
// misaligned word and reset during REQ.
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'h0;
  logic [31:0] core_wd_i = 32'h0;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i = 32'h0;
  logic        mem_ready_i = 1'b0;
  logic        err_o;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs[11];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
  endtask

  task automatic finish_core();
    core_req_i  = 1'b0;
    mem_ready_i = 1'b0;
    tick();
  endtask

  // One access with ready in the first REQ cycle.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    start(v.we, v.size, v.addr, v.wd);
    #1 chk1($sformatf("v%0d stall_idle", i), core_stall_o, 1'b1);
    tick();
    chk1($sformatf("v%0d req", i), mem_req_o, 1'b1);
    chk1($sformatf("v%0d we", i), mem_we_o, v.we);
    chk($sformatf("v%0d be", i), 32'(mem_be_o), 32'(v.e_be));
    chk($sformatf("v%0d addr", i), mem_addr_o, v.e_addr);
    chk($sformatf("v%0d wd", i), mem_wd_o, v.e_wd);
    chk1($sformatf("v%0d err_req", i), err_o, v.e_err);
    chk1($sformatf("v%0d stall_req", i), core_stall_o, 1'b1);
    mem_ready_i = 1'b1;
    mem_rd_i    = v.rd;
    tick();
    chk1($sformatf("v%0d req_done", i), mem_req_o, 1'b0);
    chk1($sformatf("v%0d stall_done", i), core_stall_o, 1'b0);
    chk1($sformatf("v%0d err_done", i), err_o, 1'b0);
    chk($sformatf("v%0d rd", i), core_rd_o, v.e_rd);
    finish_core();
  endtask

  initial begin
    //            we    size  addr      wd            rd            be     addr      wd            rd            err
    vecs[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'd0, 32'h13, 32'h0,        32'h80123456, 4'h8, 32'h10, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 3'd4, 32'h13, 32'h0,        32'h80123456, 4'h8, 32'h10, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 32'h22, 32'h1234,     32'h0,        4'hC, 32'h20, 32'h12341234, 32'h00000080, 1'b0};
    vecs[4]  = '{1'b0, 3'd1, 32'h22, 32'h0,        32'h80017FFF, 4'hC, 32'h20, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[5]  = '{1'b0, 3'd5, 32'h20, 32'h0,        32'h8001F00D, 4'h3, 32'h20, 32'h0,        32'h0000F00D, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 32'h11, 32'h0,        32'h00007F00, 4'h2, 32'h10, 32'h0,        32'h0000007F, 1'b0};
    vecs[7]  = '{1'b1, 3'd0, 32'h12, 32'hAB,       32'h0,        4'h4, 32'h10, 32'hABABABAB, 32'h0000007F, 1'b0};
    vecs[8]  = '{1'b0, 3'd2, 32'h40, 32'h0,        32'h12345678, 4'hF, 32'h40, 32'h0,        32'h12345678, 1'b0};
    vecs[9]  = '{1'b0, 3'd3, 32'h44, 32'h0,        32'hCAFEBABE, 4'hF, 32'h44, 32'h0,        32'hCAFEBABE, 1'b1};
    vecs[10] = '{1'b1, 3'd6, 32'h4A, 32'h11223344, 32'h0,        4'hF, 32'h48, 32'h11223344, 32'hCAFEBABE, 1'b1};

    // Reset state.
    #12;
    chk1("rst req", mem_req_o, 1'b0);
    chk1("rst we", mem_we_o, 1'b0);
    chk("rst be", 32'(mem_be_o), 32'h0);
    chk("rst addr", mem_addr_o, 32'h0);
    chk("rst wd", mem_wd_o, 32'h0);
    chk("rst rd", core_rd_o, 32'h0);
    chk1("rst err", err_o, 1'b0);
    chk1("rst stall", core_stall_o, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(i);

    // Ready outside REQ is ignored.
    mem_ready_i = 1'b1;
    tick();
    chk1("idle ready no req", mem_req_o, 1'b0);
    mem_ready_i = 1'b0;

    // LW at a misaligned address 0x06.
    start(1'b0, 3'd2, 32'h06, 32'h0);
    tick();
`ifdef LSU_MISALIGN_TRAP_EN
    chk1("mis req", mem_req_o, 1'b0);
    chk1("mis err", err_o, 1'b1);
    chk("mis rd", core_rd_o, 32'h0);
    chk1("mis stall", core_stall_o, 1'b0);
    finish_core();
`else
    chk1("mis req", mem_req_o, 1'b1);
    chk("mis addr", mem_addr_o, 32'h04);
    chk("mis be", 32'(mem_be_o), 32'hF);
    chk1("mis err", err_o, 1'b0);
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'h55AA55AA;
    tick();
    chk("mis rd", core_rd_o, 32'h55AA55AA);
    chk1("mis err_done", err_o, 1'b0);
    finish_core();
`endif

    // Timeout: 4 REQ cycles with no ready, then DONE with error.
    mem_rd_i = 32'hFFFFFFFF;
    start(1'b0, 3'd2, 32'h50, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk1($sformatf("to req c%0d", c), mem_req_o, 1'b1);
      chk1($sformatf("to err c%0d", c), err_o, 1'b0);
    end
    tick();
    chk1("to req done", mem_req_o, 1'b0);
    chk1("to err done", err_o, 1'b1);
    chk1("to stall done", core_stall_o, 1'b0);
    chk("to rd", core_rd_o, 32'h0);
    finish_core();
    chk1("to err pulse end", err_o, 1'b0);

    // Ready in the last permitted REQ cycle wins over timeout.
    start(1'b0, 3'd2, 32'h54, 32'h0);
    for (int c = 1; c <= 4; c++) tick();
    chk1("rw req c4", mem_req_o, 1'b1);
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'h0BADF00D;
    tick();
    chk1("rw err", err_o, 1'b0);
    chk("rw rd", core_rd_o, 32'h0BADF00D);
    finish_core();

    // Drop of core_req during REQ does not abort.
    start(1'b0, 3'd5, 32'h62, 32'h0);
    tick();
    core_req_i = 1'b0;
    tick();
    chk1("drop req held", mem_req_o, 1'b1);
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'hBEEF0000;
    tick();
    chk("drop rd", core_rd_o, 32'h0000BEEF);
    finish_core();

    // Reset during REQ drops the request asynchronously.
    start(1'b0, 3'd2, 32'h70, 32'h0);
    tick();
    chk1("mrst req before", mem_req_o, 1'b1);
    rst_i = 1'b1;
    #1 chk1("mrst req async", mem_req_o, 1'b0);
    chk("mrst rd", core_rd_o, 32'h0);
    core_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    run_vec(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the processor core's memory port and the data memory. Latches each core access, drives the data memory with a word-aligned address, byte enables and replicated write data, waits for `mem_ready_i`, then returns sign/zero-extended load data. It generates the core stall in place of the free-running stall toggle, and it bounds every access with a timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of cycles spent in REQ without `mem_ready_i` before the access is aborted; legal range 1..65535.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `core_req_i` in 1: core requests a memory access; held stable with all `core_*` inputs while `core_stall_o`=1.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: RISC-V funct3. 0=B, 1=H, 2=W, 4=BU, 5=HU.
- `core_addr_i` in 32: byte address.
- `core_wd_i` in 32: store data, LSB-aligned.
- `core_rd_o` out 32: formatted load data, registered, valid in DONE.
- `core_stall_o` out 1: hold the core.
- `mem_req_o` out 1: data memory request.
- `mem_we_o` out 1: data memory write enable.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word address, bits [1:0] always 0.
- `mem_wd_o` out 32: replicated write data.
- `mem_rd_i` in 32: memory read word.
- `mem_ready_i` in 1: memory completes the access this cycle.
- `err_o` out 1: one-cycle pulse on misalignment trap, timeout or illegal size.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, when `core_req_i`=1: latch we, size, addr and wd, then go to REQ.
- REQ:
  - `mem_req_o`=1, with memory outputs driven from the latched registers.
  - Wait-cycle counter increments each cycle.
  - On `mem_ready_i`=1: capture formatted `mem_rd_i` into `core_rd_o` (loads only; stores leave it unchanged), go to DONE.
  - When the counter reaches `TIMEOUT_CYCLES`: drop the request, `core_rd_o`=0, pulse `err_o`, go to DONE.
- DONE: the core advances this cycle. Return to IDLE unconditionally; a new request is accepted in the next IDLE cycle.
- `core_stall_o` = `core_req_i` & (state != DONE), combinational.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << {addr[1],1'b0}.
  - W: 4'b1111.
  - Loads assert the same enables as stores.
- Write data: B gives {4{wd[7:0]}}, H gives {2{wd[15:0]}}, W gives wd.
- Read data:
  - B/BU select the byte `mem_rd_i[8*addr[1:0] +: 8]`; H/HU select the halfword `mem_rd_i[16*addr[1] +: 16]`.
  - B and H sign-extend; BU and HU zero-extend.
- Illegal size (3, 6, 7): performed as a word access, with an `err_o` pulse on entry to REQ.
- A drop of `core_req_i` during REQ does not abort. The memory transaction completes and the FSM passes through DONE.
- `rst_i` during REQ: immediate return to IDLE, `mem_req_o`=0 asynchronously, in-flight result discarded.

## Timing
- Reset values: state IDLE, `core_rd_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_be_o`=0, `mem_addr_o`=0, `mem_wd_o`=0, `err_o`=0, counter 0.
- Memory outputs are registered. They are zero whenever state != REQ.
- Request seen in IDLE at cycle 0:
  - REQ in cycles 1..k, where `mem_ready_i` is high in cycle k.
  - DONE in cycle k+1, with `core_rd_o` valid.
  - Minimum access is 3 cycles, with 2 stall cycles.
- Timeout: with no ready, REQ lasts exactly `TIMEOUT_CYCLES` cycles, then DONE.
- `mem_ready_i` outside REQ is ignored.
- Ready in the same cycle the counter hits the limit: ready wins, no error.
- The counter saturates and does not wrap. It clears on entry to REQ.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned H/HU (addr[0]=1) or W (addr[1:0]!=0) access goes IDLE → DONE with no memory request.
  - `core_rd_o`=0 and `err_o` pulses.
- Undefined: low address bits are forced aligned (H clears addr[0], W clears addr[1:0]) and the access proceeds normally with no error.

## Test plan
- SW addr 0x10, wd 0xDEADBEEF, ready in first REQ cycle:
  - `mem_be_o`=1111 and `mem_addr_o`=0x10.
  - Stall is high for 2 cycles, then low in DONE.
- LB addr 0x13, `mem_rd_i`=0x80xxxxxx → `core_rd_o`=0xFFFFFF80. LBU on the same access → 0x00000080.
- SH addr 0x22, wd 0x1234 → `mem_be_o`=1100 and `mem_wd_o`=0x12341234.
- LW with ready held low and `TIMEOUT_CYCLES`=4:
  - 4 REQ cycles, then `err_o` pulses for one cycle.
  - `core_rd_o`=0 and stall releases.
- LW addr 0x06:
  - With `LSU_MISALIGN_TRAP_EN`: no `mem_req_o`, `err_o` pulses, DONE at cycle 1.
  - Without it: `mem_addr_o`=0x04 and a normal access.
- `rst_i` asserted mid-REQ → `mem_req_o` drops the same cycle and the FSM is in IDLE. The next access completes normally.
